echo_mix_stage: RTL and testbench

//  Downstream of the delay-line sample store. Pairs each dry codec sample with the

---
 rtl/echo_mix_stage.sv | 95 +++++++++
 tb/tb_echo_mix_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_mix_stage.sv
// echo_mix_stage: pairs dry and delayed samples, scales delayed by gain, sums, emits wet sample.
// Define ECHO_MIX_SAT_EN for saturating sum and sticky sat_flag; otherwise the sum wraps.
module echo_mix_stage #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 8
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic [DATA_W-1:0] dry_data,
  input  logic              dry_valid,
  output logic              dry_ready,
  input  logic [DATA_W-1:0] dly_data,
  input  logic              dly_valid,
  output logic              dly_ready,
  input  logic [GAIN_W-1:0] gain,
  input  logic              bypass,
  output logic [DATA_W-1:0] mix_data,
  output logic              mix_valid,
  input  logic              mix_ready
`ifdef ECHO_MIX_SAT_EN
  ,
  output logic              sat_flag
`endif
);
  localparam int PW = DATA_W + GAIN_W + 1;
  typedef enum logic [1:0] {COLLECT, MULT, SUM, OUT} state_t;
  state_t state, nstate;
  logic dry_held, dly_held, dry_held_n, dly_held_n, dry_cap, dly_cap, fire;
  logic [DATA_W-1:0] dry_q, dly_q, result;
  logic signed [PW-1:0] dly_x, gain_x;
  logic signed [DATA_W:0] scaled, sum;
`ifdef ECHO_MIX_SAT_EN
  logic clamp;
`endif
  always_comb begin
    dry_cap = dry_valid & dry_ready;
    dly_cap = dly_valid & dly_ready;
    fire = mix_valid & mix_ready;
    dry_held_n = fire ? 1'b0 : dry_held | dry_cap;
    dly_held_n = fire ? 1'b0 : dly_held | dly_cap;
    nstate = COLLECT;
    case (state)
      COLLECT: nstate = (dry_held & dly_held) ? MULT : COLLECT;
      MULT:    nstate = SUM;
      SUM:     nstate = OUT;
      OUT:     nstate = fire ? COLLECT : OUT;
      default: nstate = COLLECT;
    endcase
  end
  // Gain is zero-extended so the product stays signed; PW bits cannot overflow.
  always_comb begin
    dly_x = PW'($signed(dly_q));
    gain_x = PW'({1'b0, gain});
    sum = (DATA_W + 1)'($signed(dry_q)) + scaled;
`ifdef ECHO_MIX_SAT_EN
    clamp = sum[DATA_W] ^ sum[DATA_W-1];
    result = bypass ? dry_q :
             !clamp ? DATA_W'(sum) :
             sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
    result = bypass ? dry_q : DATA_W'(sum);
`endif
  end
  always_ff @(posedge clk50) begin
    if (rst) begin
      state <= COLLECT;
      dry_held <= 1'b0;
      dly_held <= 1'b0;
      dry_ready <= 1'b0;
      dly_ready <= 1'b0;
      mix_valid <= 1'b0;
      mix_data <= '0;
      dry_q <= '0;
      dly_q <= '0;
      scaled <= '0;
    end else begin
      state <= nstate;
      dry_held <= dry_held_n;
      dly_held <= dly_held_n;
      dry_ready <= (nstate == COLLECT) & ~dry_held_n;
      dly_ready <= (nstate == COLLECT) & ~dly_held_n;
      mix_valid <= nstate == OUT;
      if (dry_cap) dry_q <= dry_data;
      if (dly_cap) dly_q <= dly_data;
      if (state == MULT) scaled <= (DATA_W + 1)'((dly_x * gain_x) >>> GAIN_W);
      if (state == SUM) mix_data <= result;
    end
  end
`ifdef ECHO_MIX_SAT_EN
  always_ff @(posedge clk50) begin
    if (rst) sat_flag <= 1'b0;
    else if (state == SUM && !bypass && clamp) sat_flag <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_echo_mix_stage.sv
// tb_echo_mix_stage: scoreboard bench for echo_mix_stage; expected samples queued at stimulus time.
module tb_echo_mix_stage;
  logic clk50 = 1'b0;
  logic rst = 1'b1;
  logic [15:0] dry_data = '0, dly_data = '0;
  logic dry_valid = 1'b0, dly_valid = 1'b0;
  logic dry_ready, dly_ready;
  logic [7:0] gain = '0;
  logic bypass = 1'b0;
  logic [15:0] mix_data;
  logic mix_valid;
  logic mix_ready = 1'b1;
`ifdef ECHO_MIX_SAT_EN
  logic sat_flag;
`endif
  int n_chk = 0, n_bad = 0, xfers = 0;
  int q[$];
  bit rnd_on = 1'b0;

  echo_mix_stage dut (
    .clk50(clk50), .rst(rst),
    .dry_data(dry_data), .dry_valid(dry_valid), .dry_ready(dry_ready),
    .dly_data(dly_data), .dly_valid(dly_valid), .dly_ready(dly_ready),
    .gain(gain), .bypass(bypass),
    .mix_data(mix_data), .mix_valid(mix_valid), .mix_ready(mix_ready)
`ifdef ECHO_MIX_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #10 clk50 = ~clk50;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model(int d, int l, int g, bit bp);
    int s;
    logic signed [15:0] w;
    s = d + ((l * g) >>> 8);
    if (bp) return d;
`ifdef ECHO_MIX_SAT_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    w = 16'(s);
    return int'(w);
`endif
  endfunction

  always @(negedge clk50) begin
    if (!rst && mix_valid) begin
      if (q.size() == 0) chk("unexpected_out", $signed(mix_data), 99999);
      else begin
        chk("mix_data", $signed(mix_data), q[0]);
        if (mix_ready) begin
          void'(q.pop_front());
          xfers++;
        end
      end
      chk("rdy_in_out", {30'd0, dry_ready, dly_ready}, 0);
    end
  end

  task automatic send_dry(int v);
    bit ok = 1'b0;
    dry_data = 16'(v);
    dry_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk50);
      if (dry_ready) begin
        @(posedge clk50);
        ok = 1'b1;
      end
    end
    #1 dry_valid = 1'b0;
    if (!ok) chk("dry_accept_timeout", 0, 1);
  endtask

  task automatic send_dly(int v);
    bit ok = 1'b0;
    dly_data = 16'(v);
    dly_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk50);
      if (dly_ready) begin
        @(posedge clk50);
        ok = 1'b1;
      end
    end
    #1 dly_valid = 1'b0;
    if (!ok) chk("dly_accept_timeout", 0, 1);
  endtask

  task automatic pair(int d, int l);
    fork
      send_dry(d);
      send_dly(l);
    join
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() > 0; i++) @(negedge clk50);
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk50);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!mix_valid && n < 50) begin
      @(posedge clk50);
      #1 n++;
    end
    if (!mix_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dry_valid = 1'b0;
    dly_valid = 1'b0;
    q.delete();
    repeat (3) begin
      @(posedge clk50);
      @(negedge clk50);
      chk("rst_mix_valid", mix_valid, 0);
      chk("rst_mix_data", mix_data, 0);
      chk("rst_readys", {30'd0, dry_ready, dly_ready}, 0);
    end
    rst = 1'b0;
    @(posedge clk50);
    @(negedge clk50);
    chk("readys_after_rst", {30'd0, dry_ready, dly_ready}, 3);
`ifdef ECHO_MIX_SAT_EN
    chk("sat_flag_rst", sat_flag, 0);
`endif
    @(posedge clk50);
    #1;
  endtask

  initial begin
    int n, x0;
    do_reset();
    mix_ready = 1'b0;
    gain = 8'd0;
    q.push_back(5);
    pair(5, 7);
    wait_valid();
    do_reset();
    mix_ready = 1'b1;

    gain = 8'd128;
    q.push_back(2000);
    pair(1000, 2000);
    n = 0;
    while (n < 20) begin
      @(posedge clk50);
      #1 n++;
      if (mix_valid) break;
    end
    chk("latency", n, 3);
    drain();

    gain = 8'd64;
    q.push_back(100 + 200);
    q.push_back(-50 + (-400 >>> 2));
    fork
      begin
        send_dly(800);
        send_dly(-400);
      end
      begin
        repeat (10) @(posedge clk50);
        #1 send_dry(100);
        send_dry(-50);
      end
    join
    drain();
`ifdef ECHO_MIX_SAT_EN
    chk("sat_flag_clear", sat_flag, 0);
`endif

    gain = 8'd255;
`ifdef ECHO_MIX_SAT_EN
    q.push_back(32767);
`else
    q.push_back(-15615);
`endif
    pair(30000, 20000);
    drain();
`ifdef ECHO_MIX_SAT_EN
    chk("sat_flag_set", sat_flag, 1);
`endif

    gain = 8'd1;
    q.push_back(-4);
    pair(-3, -1);
    drain();

    bypass = 1'b1;
    gain = 8'd200;
    mix_ready = 1'b0;
    x0 = xfers;
    q.push_back(-1234);
    pair(-1234, 5000);
    wait_valid();
    repeat (8) @(posedge clk50);
    #1 mix_ready = 1'b1;
    drain();
    chk("bypass_xfers", xfers - x0, 1);
    bypass = 1'b0;

    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic signed [15:0] d, l;
          d = 16'($urandom);
          l = 16'($urandom);
          gain = 8'($urandom);
          bypass = ($urandom_range(0, 3) == 0);
          q.push_back(model(d, l, gain, bypass));
          if ($urandom_range(0, 1)) pair(d, l);
          else fork
            send_dry(d);
            begin
              repeat ($urandom_range(0, 4)) @(posedge clk50);
              #1 send_dly(l);
            end
          join
          wait_valid();
          for (int k = 0; k < 200 && mix_valid; k++) @(posedge clk50);
          #1;
        end
        rnd_on = 1'b0;
      end
      while (rnd_on) begin
        @(posedge clk50);
        #1 mix_ready = ($urandom_range(0, 2) != 0);
      end
    join
    mix_ready = 1'b1;
    drain();
    chk("final_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
